// File: rtl/pss_sequence_tx.sv
// NR primary synchronisation signal frame generator.
// Emits one frame of PAD_PRE zero samples, the 127 BPSK chips of the PSS for
// the requested N_id_2, then PAD_POST zero samples on an AXI-Stream master.
// Ports:
//   clk_i, reset_ni            clock, asynchronous active-low reset
//   start_i, N_id_2_i          single-cycle frame request and PSS identity (0..2)
//   m_axis_out_tdata/tvalid/   output stream, {Q, I} with I in the lower half
//   tready/tlast
//   busy_o                     high while a frame is being prepared or sent
module pss_sequence_tx #(
  parameter int unsigned OUT_DW    = 32,
  parameter int unsigned AMPLITUDE = 2 ** (OUT_DW / 2 - 2),
  parameter int unsigned PAD_PRE   = 56,
  parameter int unsigned PAD_POST  = 57
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic [1:0]        N_id_2_i,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  input  logic              m_axis_out_tready,
  output logic              m_axis_out_tlast,
  output logic              busy_o
);

  localparam int unsigned HALF_W    = OUT_DW / 2;
  localparam int unsigned CHIPS     = 127;
  localparam int unsigned FRAME_LEN = PAD_PRE + CHIPS + PAD_POST;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN);
  localparam int          CHIP_FIRST = int'(PAD_PRE);
  localparam int          CHIP_LAST  = int'(PAD_PRE + CHIPS - 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_LEN - 1);
  localparam logic [6:0]        LFSR_INIT = 7'b1110110;
  localparam logic [HALF_W-1:0] AMP_POS   = HALF_W'(AMPLITUDE);
  localparam logic [HALF_W-1:0] AMP_NEG   = HALF_W'(0) - AMP_POS;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ADVANCE = 2'd1;
  localparam logic [1:0] SEND    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        adv_q, adv_d;
  logic [6:0]        lfsr_q, lfsr_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic [OUT_DW-1:0] tdata_q, tdata_d;
  logic              busy_q;
  logic              enter_send;
  logic [6:0]        m0;

  // Window x(i..i+6) with x(i) in bit 0; a step appends x(i+7)=x(i+4)^x(i).
  function automatic logic [6:0] lfsr_step(input logic [6:0] w);
    return {w[4] ^ w[0], w[6:1]};
  endfunction

  function automatic logic is_chip(input logic [CNT_W-1:0] cnt);
    return (int'(cnt) >= CHIP_FIRST) && (int'(cnt) <= CHIP_LAST);
  endfunction

  // x=0 -> d=+1 -> +AMPLITUDE; x=1 -> d=-1 -> -AMPLITUDE; Q is always zero.
  function automatic logic [OUT_DW-1:0] sample_f(input logic [CNT_W-1:0] cnt,
                                                 input logic x0);
    if (is_chip(cnt)) return {HALF_W'(0), (x0 ? AMP_NEG : AMP_POS)};
    return '0;
  endfunction

  // Cyclic shift m0 = 43*N_id_2; the m-sequence period of 127 makes the mod implicit.
  always_comb begin
    case (N_id_2_i)
      2'd1:    m0 = 7'd43;
      2'd2:    m0 = 7'd86;
      default: m0 = 7'd0;
    endcase
  end

  // Next-state and next-output logic; the output sample is computed from next-state values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    adv_d      = adv_q;
    lfsr_d     = lfsr_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tdata_d    = tdata_q;
    enter_send = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && (N_id_2_i != 2'd3)) begin
          lfsr_d = LFSR_INIT;
          adv_d  = m0;
          if (m0 != 7'd0) state_d = ADVANCE;
          else            enter_send = 1'b1;
        end
      end
      ADVANCE: begin
        lfsr_d = lfsr_step(lfsr_q);
        adv_d  = adv_q - 7'd1;
        if (adv_q == 7'd1) enter_send = 1'b1;
      end
      SEND: begin
        if (m_axis_out_tready) begin
          if (cnt_q == CNT_LAST) begin
            state_d  = IDLE;
            cnt_d    = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (is_chip(cnt_q)) lfsr_d = lfsr_step(lfsr_q);
            tdata_d = sample_f(cnt_d, lfsr_d[0]);
            tlast_d = (cnt_d == CNT_LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Preload sample 0 so it is already registered in the first SEND cycle.
    if (enter_send) begin
      state_d  = SEND;
      cnt_d    = '0;
      tvalid_d = 1'b1;
      tlast_d  = 1'b0;
      tdata_d  = sample_f('0, lfsr_d[0]);
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      adv_q    <= '0;
      lfsr_q   <= LFSR_INIT;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      adv_q    <= adv_d;
      lfsr_q   <= lfsr_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign m_axis_out_tdata  = tdata_q;
  assign m_axis_out_tvalid = tvalid_q;
  assign m_axis_out_tlast  = tlast_q;
  assign busy_o            = busy_q;

endmodule
